panel_serial_out: RTL and testbench
===================================

# panel_serial_out

Drives the four-lane 74LV595 output chain that mirrors the panel registers (op code, start value, select value, C register) onto the front-panel indicators. It snapshots the panel values, shifts them out MSB-first as four parallel 16-bit lanes, then pulses the storage clock to latch them. It sits inside `soc_top` between the panel register file and the `serial_out_*` pins.

## Interface
Parameters:
- `DIV`, 1: clk cycles per SRCLK/RCLK half-period; legal range 1..255.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `pnl_op_code`  in  6  op code to display
- `pnl_strt_value`  in  12  start value to display
- `pnl_sel_value`  in  12  select value to display
- `pnl_reg_c_value`  in  31  C register to display
- `serial_out_srclk`  out  1  shift clock to all eight 595s
- `serial_out_rclk`  out  1  storage clock to all eight 595s
- `serial_out_ser_0..3`  out  1 each  serial data, lanes 0..3
- `busy`  out  1  high from LOAD through the end of LATCH
- `frame_done`  out  1  one-cycle pulse on the last LATCH cycle

## Operation
- Lane packing at LOAD, 16 bits each:
  - lane0 = reg_c[15:0]
  - lane1 = {1'b0, reg_c[30:16]}
  - lane2 = {strt[3:0], sel[11:0]}
  - lane3 = {2'b00, op[5:0], strt[11:4]}
- Shift order is bit 15 first. After 16 shifts, lane bit k sits at chain position k: first chip Q[7:0] = bits 7:0, cascaded chip Q = bits 15:8.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
  - IDLE → LOAD after 1 cycle.
  - LOAD (1 cycle): snapshot all inputs into four 16-bit shift registers and the `last_sent` register; `busy`=1.
  - SHIFT: 16 bits, each 2·DIV cycles. During the first DIV cycles SRCLK=0 and `ser_n` = current MSB. During the next DIV cycles SRCLK=1. On the SRCLK falling edge the register shifts left and the bit counter increments. After bit 15 the FSM moves to LATCH with SRCLK=0.
  - LATCH: RCLK=1 for DIV cycles with SRCLK=0. `frame_done` pulses on the final cycle. Next state is IDLE.
- Input changes during LOAD+1..LATCH are ignored until the next LOAD.
- SRCLK and RCLK are never high in the same cycle.
- `ser_n` changes only while SRCLK=0.
- Counters: bit counter 4 bits, wraps 15→done. Divider counter 8 bits, reloads at DIV−1.
- Reset mid-frame: all outputs go to 0 the next cycle and the FSM enters IDLE. RCLK is not pulsed, so the 595 outputs keep the previous frame.

## Timing
- Reset values: srclk=0, rclk=0, ser_0..3=0, busy=0, frame_done=0, state=IDLE, last_sent=0.
- Frame length = 1 (LOAD) + 32·DIV (SHIFT) + DIV (LATCH) cycles. Add 1 IDLE cycle between frames, giving a period of 33·DIV+2 (35 at DIV=1).
- First LOAD occurs on the 2nd cycle after `resetn` rises.
- Input-to-display latency is at most 2 frame periods.
- All outputs are registered; no combinational path from inputs to pins.

## Configuration
- `PANEL_SERIAL_OUT_CHANGE_ONLY_EN`
  - Defined: IDLE → LOAD only when the packed current inputs differ from `last_sent`, or on the first frame after reset. Otherwise the FSM stays in IDLE with `busy`=0.
  - Undefined: frames repeat back-to-back unconditionally at the 33·DIV+2 period.

## Structure
- Package `panel_serial_pkg`:
  - `LANE_W`=16, `LANES`=4
  - state enum {IDLE, LOAD, SHIFT, LATCH}
  - function `pack_lanes(op, strt, sel, reg_c)` returning the 64-bit lane vector (shared with the serial-in reader and the bench)
- Sub-module `panel_serial_out_lane`: 16-bit MSB-first load/shift register with `load`, `shift`, and `ser` outputs, instantiated four times. The FSM and divider stay in the top.

## Test plan
- Pack and shift, DIV=1, inputs op=6'h2D, strt=12'hABC, sel=12'h123, reg_c=31'h2AAA_1234 → bench 595 models read lanes 16'h1234, 16'h2AAA, 16'hC123, 16'h2DAB after the first `frame_done`; decoded panel values match the inputs.
- Timing, DIV=3 → 16 SRCLK rising edges each 6 cycles apart. RCLK is high for exactly 3 cycles after the last SRCLK fall and never overlaps SRCLK. Frame period is 101 cycles.
- Input change mid-SHIFT (reg_c 0→31'h7FFF_FFFF at bit 5) → current frame latches 0. The next frame latches lane0=16'hFFFF and lane1=16'h7FFF.
- Reset asserted at SHIFT bit 8 → next cycle all outputs 0 and no RCLK pulse. The 595 outputs hold the prior frame. After release, the first LOAD occurs 2 cycles later.
- With `PANEL_SERIAL_OUT_CHANGE_ONLY_EN`:
  - Constant inputs → exactly one frame after reset, then `busy`=0 indefinitely.
  - Changing sel to 12'h456 → one new frame, with lane2=16'hC456.
- Without the macro, constant inputs → `frame_done` every 33·DIV+2 cycles over 10 frames.

Source files
------------

// File: rtl/panel_serial_pkg.sv
// Shared definitions for the front-panel 74LV595 serial chain: lane geometry,
// FSM state encoding and the lane packing used by the writer, reader and bench.
package panel_serial_pkg;

  localparam int LANE_W  = 16;
  localparam int LANES   = 4;
  localparam int FRAME_W = LANE_W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Packs the panel registers into {lane3, lane2, lane1, lane0}; lane0 is bits 15:0.
  function automatic logic [FRAME_W-1:0] pack_lanes(
    input logic [5:0]  op,
    input logic [11:0] strt,
    input logic [11:0] sel,
    input logic [30:0] reg_c
  );
    pack_lanes = {2'b00, op, strt[11:4],
                  strt[3:0], sel,
                  1'b0, reg_c[30:16],
                  reg_c[15:0]};
  endfunction

endpackage

// File: rtl/panel_serial_out_lane.sv
// One 16-bit MSB-first load/shift register feeding a single 595 cascade.
// Zeros are shifted in behind the data, so the line idles low once a frame
// has been fully shifted out.
module panel_serial_out_lane
  import panel_serial_pkg::*;
#(
  parameter int DATA_W = LANE_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              ser
);

  logic [DATA_W-1:0] sr;

  // Snapshot on load, otherwise move one bit toward the MSB on each shift.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[DATA_W-2:0], 1'b0};
    end
  end

  assign ser = sr[DATA_W-1];

endmodule

// File: rtl/panel_serial_out.sv
// Front-panel serial writer: snapshots the panel registers, shifts them out on
// four parallel lanes MSB-first, then pulses RCLK to latch the 595 chain.
// Optional build macro PANEL_SERIAL_OUT_CHANGE_ONLY_EN: only send a frame when
// the packed inputs differ from the last frame sent (or first after reset).
module panel_serial_out
  import panel_serial_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  pnl_op_code,
  input  logic [11:0] pnl_strt_value,
  input  logic [11:0] pnl_sel_value,
  input  logic [30:0] pnl_reg_c_value,
  output logic        serial_out_srclk,
  output logic        serial_out_rclk,
  output logic        serial_out_ser_0,
  output logic        serial_out_ser_1,
  output logic        serial_out_ser_2,
  output logic        serial_out_ser_3,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t             state, state_nxt;
  logic [7:0]         div_cnt, div_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic               phase, phase_nxt;
  logic               load, shift, start;
  logic               srclk_nxt, rclk_nxt, busy_nxt, done_nxt;
  logic [FRAME_W-1:0] frame_in;
  logic [LANES-1:0]   ser_lane;

  assign frame_in = pack_lanes(pnl_op_code, pnl_strt_value, pnl_sel_value, pnl_reg_c_value);

`ifdef PANEL_SERIAL_OUT_CHANGE_ONLY_EN
  logic [FRAME_W-1:0] last_sent;
  logic               first_pending;

  assign start = first_pending || (frame_in != last_sent);

  // Remember what the panel currently shows so unchanged inputs cost no frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_sent     <= '0;
      first_pending <= 1'b1;
    end else if (load) begin
      last_sent     <= frame_in;
      first_pending <= 1'b0;
    end
  end
`else
  assign start = 1'b1;
`endif

  // Next-state, counters and next output values; outputs are then registered.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    phase_nxt = phase;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SHIFT;
        div_nxt   = '0;
        bit_nxt   = '0;
        phase_nxt = 1'b0;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
          end else begin
            // SRCLK falling edge: advance data and bit position together.
            phase_nxt = 1'b0;
            shift     = 1'b1;
            bit_nxt   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_nxt = LATCH;
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    srclk_nxt = (state_nxt == SHIFT) && phase_nxt;
    rclk_nxt  = (state_nxt == LATCH);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == LATCH) && (div_nxt == DIV_LAST);
  end

  // State, counters and registered pin drivers; reset drops every pin low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      phase            <= 1'b0;
      serial_out_srclk <= 1'b0;
      serial_out_rclk  <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state            <= state_nxt;
      div_cnt          <= div_nxt;
      bit_cnt          <= bit_nxt;
      phase            <= phase_nxt;
      serial_out_srclk <= srclk_nxt;
      serial_out_rclk  <= rclk_nxt;
      busy             <= busy_nxt;
      frame_done       <= done_nxt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    panel_serial_out_lane #(
      .DATA_W (LANE_W)
    ) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .load   (load),
      .shift  (shift),
      .din    (frame_in[g*LANE_W +: LANE_W]),
      .ser    (ser_lane[g])
    );
  end

  assign serial_out_ser_0 = ser_lane[0];
  assign serial_out_ser_1 = ser_lane[1];
  assign serial_out_ser_2 = ser_lane[2];
  assign serial_out_ser_3 = ser_lane[3];

endmodule

// File: tb/tb_panel_serial_out.sv
// Bench for panel_serial_out: two instances (DIV=1 and DIV=3) driven from the
// same panel inputs, each observed by a behavioural 595 chain per lane.
module tb_panel_serial_out;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  op;
  logic [11:0] strt, sel;
  logic [30:0] reg_c;

  logic       srclk [2];
  logic       rclk  [2];
  logic       busy  [2];
  logic       done  [2];
  logic [3:0] ser   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panel_serial_out #(.DIV(1)) dut0 (
    .clk              (clk),
    .resetn           (resetn),
    .pnl_op_code      (op),
    .pnl_strt_value   (strt),
    .pnl_sel_value    (sel),
    .pnl_reg_c_value  (reg_c),
    .serial_out_srclk (srclk[0]),
    .serial_out_rclk  (rclk[0]),
    .serial_out_ser_0 (ser[0][0]),
    .serial_out_ser_1 (ser[0][1]),
    .serial_out_ser_2 (ser[0][2]),
    .serial_out_ser_3 (ser[0][3]),
    .busy             (busy[0]),
    .frame_done       (done[0])
  );

  panel_serial_out #(.DIV(3)) dut1 (
    .clk              (clk),
    .resetn           (resetn),
    .pnl_op_code      (op),
    .pnl_strt_value   (strt),
    .pnl_sel_value    (sel),
    .pnl_reg_c_value  (reg_c),
    .serial_out_srclk (srclk[1]),
    .serial_out_rclk  (rclk[1]),
    .serial_out_ser_0 (ser[1][0]),
    .serial_out_ser_1 (ser[1][1]),
    .serial_out_ser_2 (ser[1][2]),
    .serial_out_ser_3 (ser[1][3]),
    .busy             (busy[1]),
    .frame_done       (done[1])
  );

  // 595 chain model and pin-level observers, sampled on the falling clk edge.
  int          cyc = 0;
  logic        srclk_q [2] = '{default: 1'b0};
  logic        rclk_q  [2] = '{default: 1'b0};
  logic        busy_q  [2] = '{default: 1'b0};
  logic [3:0]  ser_q   [2] = '{default: 4'h0};
  logic [15:0] sreg [2][4] = '{default: '{default: 16'h0}};
  logic [15:0] q    [2][4] = '{default: '{default: 16'h0}};
  int rises       [2] = '{default: 0};
  int rise_cyc [2][16] = '{default: '{default: 0}};
  int load_cyc    [2] = '{default: 0};
  int rclk_hi     [2] = '{default: 0};
  int rclk_first  [2] = '{default: 0};
  int last_fall   [2] = '{default: 0};
  int overlap     [2] = '{default: 0};
  int ser_viol    [2] = '{default: 0};
  int rclk_pulses [2] = '{default: 0};
  int busy_rises  [2] = '{default: 0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      srclk_q[d] <= srclk[d];
      rclk_q[d]  <= rclk[d];
      busy_q[d]  <= busy[d];
      ser_q[d]   <= ser[d];
      if (busy[d] && !busy_q[d]) begin
        load_cyc[d]   <= cyc;
        rises[d]      <= 0;
        rclk_hi[d]    <= 0;
        busy_rises[d] <= busy_rises[d] + 1;
      end
      if (srclk[d] && !srclk_q[d]) begin
        for (int l = 0; l < 4; l++) sreg[d][l] <= {sreg[d][l][14:0], ser[d][l]};
        if (rises[d] < 16) rise_cyc[d][rises[d]] <= cyc;
        rises[d] <= rises[d] + 1;
      end
      if (!srclk[d] && srclk_q[d]) last_fall[d] <= cyc;
      if (rclk[d]) begin
        rclk_hi[d] <= rclk_hi[d] + 1;
        if (!rclk_q[d]) begin
          rclk_first[d]  <= cyc;
          rclk_pulses[d] <= rclk_pulses[d] + 1;
          for (int l = 0; l < 4; l++) q[d][l] <= sreg[d][l];
        end
      end
      if (srclk[d] && rclk[d]) overlap[d] <= overlap[d] + 1;
      if (srclk[d] && srclk_q[d] && (ser[d] != ser_q[d])) ser_viol[d] <= ser_viol[d] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_done(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy_rise(input int d, input int budget, output bit ok);
    int b0;
    b0 = busy_rises[d];
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy_rises[d] != b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int d, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rises[d] >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    op = '0; strt = '0; sel = '0; reg_c = '0;
    resetn = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({srclk[d], rclk[d], ser[d], busy[d], done[d]} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b want 00000000", d,
                 {srclk[d], rclk[d], ser[d], busy[d], done[d]});
      end
    end
    resetn = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], srclk[d], rclk[d]} !== 3'b100) begin
        errors++;
        $display("FAIL first_load dut%0d: busy/srclk/rclk got %b want 100", d,
                 {busy[d], srclk[d], rclk[d]});
      end
    end
  endtask

  task automatic test_pack();
    bit ok;
    logic [15:0] exp_lane [4];
    exp_lane = '{16'h1234, 16'h2AAA, 16'hC123, 16'h2DAB};
    op = 6'h2D; strt = 12'hABC; sel = 12'h123; reg_c = 31'h2AAA_1234;
    do_reset();
    wait_done(0, 100, ok);
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL pack_done_dut0: timeout got 0 want 1"); end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (q[0][l] !== exp_lane[l]) begin
        errors++;
        $display("FAIL pack_lane%0d_dut0: got %h want %h", l, q[0][l], exp_lane[l]);
      end
    end
    checks++;
    if (q[0][3][13:8] !== 6'h2D) begin errors++; $display("FAIL decode_op: got %h want 2d", q[0][3][13:8]); end
    checks++;
    if ({q[0][3][7:0], q[0][2][15:12]} !== 12'hABC) begin
      errors++; $display("FAIL decode_strt: got %h want abc", {q[0][3][7:0], q[0][2][15:12]});
    end
    checks++;
    if (q[0][2][11:0] !== 12'h123) begin errors++; $display("FAIL decode_sel: got %h want 123", q[0][2][11:0]); end
    checks++;
    if ({q[0][1][14:0], q[0][0]} !== 31'h2AAA_1234) begin
      errors++; $display("FAIL decode_reg_c: got %h want 2aaa1234", {q[0][1][14:0], q[0][0]});
    end
    wait_done(1, 300, ok);
    tick();
    checks++;
    if (!ok || {q[1][3], q[1][2], q[1][1], q[1][0]} !== 64'h2DAB_C123_2AAA_1234) begin
      errors++;
      $display("FAIL pack_dut1: got %h%h%h%h want 2dabc1232aaa1234", q[1][3], q[1][2], q[1][1], q[1][0]);
    end
  endtask

  task automatic test_timing();
    bit ok;
    int bad, t0;
    do_reset();
    wait_done(1, 300, ok);
    t0 = cyc;
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL timing_done: timeout got 0 want 1"); end
    checks++;
    if (rises[1] !== 16) begin errors++; $display("FAIL srclk_rises: got %0d want 16", rises[1]); end
    checks++;
    if (rise_cyc[1][0] - load_cyc[1] !== 4) begin
      errors++; $display("FAIL first_rise_offset: got %0d want 4", rise_cyc[1][0] - load_cyc[1]);
    end
    bad = 0;
    for (int k = 1; k < 16; k++) if (rise_cyc[1][k] - rise_cyc[1][k-1] != 6) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL srclk_spacing: bad gaps got %0d want 0", bad); end
    checks++;
    if (rclk_hi[1] !== 3) begin errors++; $display("FAIL rclk_width: got %0d want 3", rclk_hi[1]); end
    checks++;
    if (rclk_first[1] !== last_fall[1]) begin
      errors++; $display("FAIL rclk_after_fall: rclk at %0d want %0d", rclk_first[1], last_fall[1]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (overlap[d] !== 0) begin errors++; $display("FAIL overlap_dut%0d: got %0d want 0", d, overlap[d]); end
      checks++;
      if (ser_viol[d] !== 0) begin errors++; $display("FAIL ser_stable_dut%0d: got %0d want 0", d, ser_viol[d]); end
    end
`ifndef PANEL_SERIAL_OUT_CHANGE_ONLY_EN
    wait_done(1, 300, ok);
    checks++;
    if (!ok || cyc - t0 !== 101) begin
      errors++; $display("FAIL period_div3: got %0d want 101", cyc - t0);
    end
`endif
  endtask

  task automatic test_midshift();
    bit ok;
    op = '0; strt = '0; sel = '0; reg_c = '0;
    do_reset();
    wait_busy_rise(0, 20, ok);
    wait_rises(0, 5, 40, ok);
    reg_c = 31'h7FFF_FFFF;
    wait_done(0, 100, ok);
    tick();
    checks++;
    if (!ok || q[0][0] !== 16'h0 || q[0][1] !== 16'h0) begin
      errors++; $display("FAIL midshift_current: got %h %h want 0000 0000", q[0][1], q[0][0]);
    end
    wait_done(0, 100, ok);
    tick();
    checks++;
    if (!ok || q[0][0] !== 16'hFFFF) begin errors++; $display("FAIL midshift_next_lane0: got %h want ffff", q[0][0]); end
    checks++;
    if (q[0][1] !== 16'h7FFF) begin errors++; $display("FAIL midshift_next_lane1: got %h want 7fff", q[0][1]); end
    checks++;
    if ({q[0][3], q[0][2]} !== 32'h0) begin errors++; $display("FAIL midshift_next_upper: got %h%h want 0", q[0][3], q[0][2]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int p0;
    reg_c = '0;
    wait_busy_rise(0, 100, ok);
    wait_rises(0, 8, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_reach: timeout got 0 want 1"); end
    p0 = rclk_pulses[0];
    resetn = 1'b0;
    tick();
    checks++;
    if ({srclk[0], rclk[0], ser[0], busy[0], done[0]} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_outputs: got %b want 00000000", {srclk[0], rclk[0], ser[0], busy[0], done[0]});
    end
    repeat (3) tick();
    checks++;
    if (rclk_pulses[0] !== p0) begin errors++; $display("FAIL reset_mid_rclk: pulses got %0d want %0d", rclk_pulses[0], p0); end
    checks++;
    if (q[0][0] !== 16'hFFFF || q[0][1] !== 16'h7FFF) begin
      errors++; $display("FAIL reset_mid_hold: got %h %h want 7fff ffff", q[0][1], q[0][0]);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_mid_reload: busy got %b want 1", busy[0]); end
  endtask

`ifdef PANEL_SERIAL_OUT_CHANGE_ONLY_EN
  task automatic test_change_only();
    bit ok;
    int b0;
    op = 6'h2D; strt = 12'hABC; sel = 12'h123; reg_c = 31'h2AAA_1234;
    do_reset();
    wait_done(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL change_first_frame: timeout got 0 want 1"); end
    b0 = busy_rises[0];
    repeat (300) tick();
    checks++;
    if (busy_rises[0] !== b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL change_idle: extra frames got %0d want 0", busy_rises[0] - b0);
    end
    checks++;
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL change_idle_dut1: busy got %b want 0", busy[1]); end
    sel = 12'h456;
    wait_done(0, 100, ok);
    tick();
    checks++;
    if (!ok || q[0][2] !== 16'hC456) begin errors++; $display("FAIL change_new_lane2: got %h want c456", q[0][2]); end
    b0 = busy_rises[0];
    repeat (100) tick();
    checks++;
    if (busy_rises[0] !== b0) begin errors++; $display("FAIL change_single: extra frames got %0d want 0", busy_rises[0] - b0); end
  endtask
`else
  task automatic test_back_to_back();
    bit ok;
    int t0;
    op = 6'h15; strt = 12'h321; sel = 12'h0F0; reg_c = 31'h1234_5678;
    do_reset();
    wait_done(0, 100, ok);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_done(0, 100, ok);
      checks++;
      if (!ok || cyc - t0 !== 35) begin
        errors++; $display("FAIL period_frame%0d: got %0d want 35", i, cyc - t0);
      end
      t0 = cyc;
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    op = '0; strt = '0; sel = '0; reg_c = '0;
    test_reset();
    test_pack();
    test_timing();
    test_midshift();
    test_reset_mid();
`ifdef PANEL_SERIAL_OUT_CHANGE_ONLY_EN
    test_change_only();
`else
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
